// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode to ASCII translator: pops bytes from the keyboard driver FIFO,
// tracks break/extended prefixes and Shift/Ctrl/Caps state, presents characters on valid/ready.
//
// state  | meaning
// IDLE   | wait for kbd_irq with the output slot free or being accepted
// READ   | kbd_read strobe to the driver
// LATCH  | capture kbd_data[7:0] into sc
// DECODE | update prefix/modifier flags, optionally load ascii
module ps2_key_decoder #(
   parameter logic [7:0] ARROW_BASE = 8'h80,
   parameter bit         CTRL_MAP   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        kbd_irq,
   output logic        kbd_read,
   input  logic [15:0] kbd_data,
   output logic [7:0]  ascii,
   output logic        ascii_valid,
   input  logic        ascii_ready,
   output logic        shift_held,
   output logic        ctrl_held,
   output logic        caps_lock
);

   typedef enum logic [1:0] {IDLE, READ, LATCH, DECODE} state_t;

   state_t      state, state_nx;
   logic [7:0]  sc, sc_nx, ascii_nx, ch;
   logic        brk, brk_nx, ext, ext_nx;
   logic        lshift, lshift_nx, rshift, rshift_nx;
   logic        lctrl, lctrl_nx, rctrl, rctrl_nx;
   logic        caps_down, caps_down_nx, caps_lock_nx;
   logic        kbd_read_nx, ascii_valid_nx, shift_held_nx, ctrl_held_nx;
   logic        start, load;
   logic [17:0] km;
   logic        unused_hi;

   assign unused_hi = ^kbd_data[15:8];
   assign start     = kbd_irq && (!ascii_valid || ascii_ready);

   // {mapped, is_letter, unshifted/lowercase char, shifted char}
   function automatic logic [17:0] keymap(input logic [7:0] code);
      case (code)
         8'h1C: keymap = {2'b11, "a", "A"};  8'h32: keymap = {2'b11, "b", "B"};
         8'h21: keymap = {2'b11, "c", "C"};  8'h23: keymap = {2'b11, "d", "D"};
         8'h24: keymap = {2'b11, "e", "E"};  8'h2B: keymap = {2'b11, "f", "F"};
         8'h34: keymap = {2'b11, "g", "G"};  8'h33: keymap = {2'b11, "h", "H"};
         8'h43: keymap = {2'b11, "i", "I"};  8'h3B: keymap = {2'b11, "j", "J"};
         8'h42: keymap = {2'b11, "k", "K"};  8'h4B: keymap = {2'b11, "l", "L"};
         8'h3A: keymap = {2'b11, "m", "M"};  8'h31: keymap = {2'b11, "n", "N"};
         8'h44: keymap = {2'b11, "o", "O"};  8'h4D: keymap = {2'b11, "p", "P"};
         8'h15: keymap = {2'b11, "q", "Q"};  8'h2D: keymap = {2'b11, "r", "R"};
         8'h1B: keymap = {2'b11, "s", "S"};  8'h2C: keymap = {2'b11, "t", "T"};
         8'h3C: keymap = {2'b11, "u", "U"};  8'h2A: keymap = {2'b11, "v", "V"};
         8'h1D: keymap = {2'b11, "w", "W"};  8'h22: keymap = {2'b11, "x", "X"};
         8'h35: keymap = {2'b11, "y", "Y"};  8'h1A: keymap = {2'b11, "z", "Z"};
         8'h16: keymap = {2'b10, "1", "!"};  8'h1E: keymap = {2'b10, "2", "@"};
         8'h26: keymap = {2'b10, "3", "#"};  8'h25: keymap = {2'b10, "4", "$"};
         8'h2E: keymap = {2'b10, "5", "%"};  8'h36: keymap = {2'b10, "6", "^"};
         8'h3D: keymap = {2'b10, "7", "&"};  8'h3E: keymap = {2'b10, "8", "*"};
         8'h46: keymap = {2'b10, "9", "("};  8'h45: keymap = {2'b10, "0", ")"};
         8'h4E: keymap = {2'b10, "-", "_"};  8'h55: keymap = {2'b10, "=", "+"};
         8'h54: keymap = {2'b10, "[", "{"};  8'h5B: keymap = {2'b10, "]", "}"};
         8'h5D: keymap = {2'b10, 8'h5C, 8'h7C}; 8'h4C: keymap = {2'b10, ";", ":"};
         8'h52: keymap = {2'b10, 8'h27, 8'h22}; 8'h41: keymap = {2'b10, ",", "<"};
         8'h49: keymap = {2'b10, ".", ">"};  8'h4A: keymap = {2'b10, "/", "?"};
         8'h0E: keymap = {2'b10, 8'h60, 8'h7E};
         8'h29: keymap = {2'b10, 8'h20, 8'h20};  8'h5A: keymap = {2'b10, 8'h0D, 8'h0D};
         8'h66: keymap = {2'b10, 8'h08, 8'h08};  8'h0D: keymap = {2'b10, 8'h09, 8'h09};
         8'h76: keymap = {2'b10, 8'h1B, 8'h1B};
         default: keymap = 18'h0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;  sc <= 8'h00;  brk <= 1'b0;  ext <= 1'b0;
         lshift <= 1'b0; rshift <= 1'b0; lctrl <= 1'b0; rctrl <= 1'b0;
         caps_down <= 1'b0; caps_lock <= 1'b0; kbd_read <= 1'b0;
         ascii <= 8'h00; ascii_valid <= 1'b0; shift_held <= 1'b0; ctrl_held <= 1'b0;
      end else begin
         state <= state_nx;  sc <= sc_nx;  brk <= brk_nx;  ext <= ext_nx;
         lshift <= lshift_nx; rshift <= rshift_nx; lctrl <= lctrl_nx; rctrl <= rctrl_nx;
         caps_down <= caps_down_nx; caps_lock <= caps_lock_nx; kbd_read <= kbd_read_nx;
         ascii <= ascii_nx; ascii_valid <= ascii_valid_nx;
         shift_held <= shift_held_nx; ctrl_held <= ctrl_held_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = READ;
         READ:    state_nx = LATCH;
         LATCH:   state_nx = DECODE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sc_nx = sc; brk_nx = brk; ext_nx = ext;
      lshift_nx = lshift; rshift_nx = rshift; lctrl_nx = lctrl; rctrl_nx = rctrl;
      caps_down_nx = caps_down; caps_lock_nx = caps_lock;
      ascii_nx = ascii; ascii_valid_nx = ascii_valid;
      kbd_read_nx = (state == IDLE) && start;
      km = keymap(sc);
      load = 1'b0;
      ch = 8'h00;
      if (ascii_valid && ascii_ready) ascii_valid_nx = 1'b0;
      case (state)
         LATCH: sc_nx = kbd_data[7:0];
         DECODE: begin
            if (sc == 8'hF0) brk_nx = 1'b1;
            else if (sc == 8'hE0) ext_nx = 1'b1;
            else begin
               brk_nx = 1'b0;
               ext_nx = 1'b0;
               case (sc)
                  8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                  8'h12: if (!ext) lshift_nx = !brk;  // E0 12 is the fake shift
                  8'h59: rshift_nx = !brk;
                  8'h14: if (ext) rctrl_nx = !brk; else lctrl_nx = !brk;
                  8'h58: begin
                     if (brk) caps_down_nx = 1'b0;
                     else if (!caps_down) begin
                        caps_lock_nx = !caps_lock;
                        caps_down_nx = 1'b1;
                     end
                  end
                  default: begin
                     if (!brk && ext) begin
                        load = 1'b1;
                        case (sc)
                           8'h75:   ch = ARROW_BASE;
                           8'h72:   ch = ARROW_BASE + 8'd1;
                           8'h6B:   ch = ARROW_BASE + 8'd2;
                           8'h74:   ch = ARROW_BASE + 8'd3;
                           default: load = 1'b0;
                        endcase
                     end else if (!brk && km[17]) begin
                        load = 1'b1;
                        if (km[16]) begin
                           if (CTRL_MAP && ctrl_held) ch = km[15:8] & 8'h1F;
                           else if (shift_held ^ caps_lock) ch = km[15:8] & 8'hDF;
                           else ch = km[15:8];
                        end else begin
                           ch = shift_held ? km[7:0] : km[15:8];
                        end
                     end
                  end
               endcase
            end
         end
         default: ;
      endcase
      if (load) begin
         ascii_nx = ch;
         ascii_valid_nx = 1'b1;
      end
      shift_held_nx = lshift_nx | rshift_nx;
      ctrl_held_nx  = lctrl_nx | rctrl_nx;
   end

endmodule
